msgdma_st_width_downconverter: RTL and testbench
================================================

Name: msgdma_st_width_downconverter

Overview:
- Avalon-ST reader on the output side of the mSGDMA timing-adapter FIFO.
- Accepts 256-bit packet beats at ready-latency 0 and serialises each beat into OUT_WIDTH-bit words for the narrow downstream sink.
- Preserves startofpacket, endofpacket and empty semantics.
- Sustains one narrow word per cycle, with no bubble between consecutive wide beats.

Parameters:
- IN_WIDTH, 256, wide data width; must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 32, narrow data width; multiple of 8.
- IN_EMPTY_WIDTH, 5, width of in_empty (log2 of IN_WIDTH/8).
- OUT_EMPTY_WIDTH, 2, width of out_empty (log2 of OUT_WIDTH/8).
- Derived localparams: RATIO = IN_WIDTH/OUT_WIDTH (8); OUT_BYTES = OUT_WIDTH/8 (4).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  wide beat valid.
- in_ready  output  1  wide beat accepted when in_valid && in_ready.
- in_data  input  IN_WIDTH  wide beat data.
- in_startofpacket  input  1  first beat of packet.
- in_endofpacket  input  1  last beat of packet.
- in_empty  input  IN_EMPTY_WIDTH  unused bytes in eop beat; ignored when in_endofpacket=0.
- out_valid  output  1  narrow word valid.
- out_ready  input  1  sink ready, ready-latency 0.
- out_data  output  OUT_WIDTH  narrow word.
- out_startofpacket  output  1  first word of packet.
- out_endofpacket  output  1  last word of packet.
- out_empty  output  OUT_EMPTY_WIDTH  unused bytes in last word; 0 on every other word.

Behaviour:
- Single clock domain: clk. reset is asynchronous, active-high.
- Reset values: out_valid=0, out_startofpacket=0, out_endofpacket=0, out_empty=0, out_data=0. Holding register is empty and lane counter is 0. in_ready=1 once reset deasserts.
- Storage: one holding register (data, sop, eop, last_lane) plus lane counter lane[log2 RATIO-1:0].
- States:
  - IDLE: holding register empty.
  - SHIFT: holding register full, out_valid=1.
- Transitions:
  - IDLE -> SHIFT on in_valid && in_ready.
  - SHIFT -> IDLE on final-lane handshake with no new beat.
  - SHIFT -> SHIFT on final-lane handshake with a simultaneous new beat.
- in_ready is combinational: !hold_full || (out_ready && lane==last_lane). It is a function of state and out_ready only; no in->out combinational path on data.
- Latency: the first narrow word of an accepted beat is valid the cycle after acceptance.
- Throughput: with out_ready held high, words stream every cycle across beat boundaries.
- Lane order: the first word is in_data[IN_WIDTH-1 -: OUT_WIDTH] (Avalon big-endian symbol order); subsequent words step toward the LSBs.
- last_lane:
  - RATIO-1 for non-eop beats.
  - For eop beats: RATIO-1 - (in_empty / OUT_BYTES), using integer division.
  - Trailing all-empty lanes are never emitted.
- Sideband:
  - out_startofpacket=1 only on lane 0 of a sop beat.
  - out_endofpacket=1 only on last_lane of an eop beat.
  - out_empty = in_empty mod OUT_BYTES on that word.
- Lane counter advances on out_valid && out_ready. It returns to 0 on the final-lane handshake.
- Stall: while out_valid && !out_ready, all out_* outputs hold stable.
- Boundary: an eop beat with in_empty >= IN_WIDTH/8 - OUT_BYTES emits exactly one word (lane 0).
- Boundary: a single-beat packet (sop && eop) emits sop and eop on the same word when only one lane is valid.
- Reset mid-beat: remaining lanes are discarded and out_valid drops immediately (asynchronous reset). No partial word is emitted afterwards.
- Protocol errors are not detected: sop/eop ordering violations pass through unchanged.

Optional Feature:
- Macro: MSGDMA_DWC_LSB_FIRST_EN.
- Defined:
  - Lane order is little-endian: the first word is in_data[OUT_WIDTH-1:0], stepping toward the MSBs.
  - On eop beats the empty bytes are taken from the MSB end. last_lane and out_empty formulas are unchanged.
- Undefined: big-endian order as in Behaviour.

Test Plan:
- Reset, then one beat (sop=1, eop=1, empty=0, data lanes 0x00000007..0x00000000 MSB-first) with out_ready=1 -> 8 consecutive words 0x7,0x6,...,0x0. sop on the first word, eop on the eighth, out_empty=0; in_ready low for cycles 1-7 after acceptance.
- Two back-to-back non-eop beats with in_valid and out_ready held high -> 16 words on 16 consecutive cycles with no gap; second beat accepted on the cycle of the first beat's word 7.
- Eop beat with in_empty=13 -> 5 words (last_lane=4); word 4 has eop=1, out_empty=1. Next beat accepted on word 4's handshake.
- Eop beat with in_empty=31 -> exactly 1 word, with sop/eop as supplied and out_empty=3.
- out_ready toggled 1,0,0,1 during word 2 -> out_data, out_valid and sideband stable across the stall. Word order and count unchanged, no duplicates.
- reset asserted for 1 cycle during word 3 of a beat -> out_valid=0 immediately. After release, the next beat's lane 0 is emitted with no residual words.

Source files
------------

// File: rtl/msgdma_st_width_downconverter.sv
// Wide-to-narrow Avalon-ST serialiser: 256-bit beats out as OUT_WIDTH words, MSB lane first (LSB first with MSB_DWC_LSB_FIRST_EN -> MSGDMA_DWC_LSB_FIRST_EN).
// Latency: first narrow word valid the cycle after a beat is accepted; one word per cycle with no bubble between beats.
// Backpressure: out_ready low freezes all out_* outputs; in_ready only rises on the final-lane handshake or when empty.
module msgdma_st_width_downconverter #(
  parameter int IN_WIDTH        = 256,
  parameter int OUT_WIDTH       = 32,
  parameter int IN_EMPTY_WIDTH  = 5,
  parameter int OUT_EMPTY_WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_WIDTH-1:0]        in_data,
  input  logic                       in_startofpacket,
  input  logic                       in_endofpacket,
  input  logic [IN_EMPTY_WIDTH-1:0]  in_empty,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_WIDTH-1:0]       out_data,
  output logic                       out_startofpacket,
  output logic                       out_endofpacket,
  output logic [OUT_EMPTY_WIDTH-1:0] out_empty
);

  localparam int RATIO     = IN_WIDTH / OUT_WIDTH;
  localparam int OUT_BYTES = OUT_WIDTH / 8;
  localparam int LANE_W    = (RATIO > 1) ? $clog2(RATIO) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]                 state;
  logic [IN_WIDTH-1:0]        hold_data;
  logic                       hold_sop;
  logic                       hold_eop;
  logic [LANE_W-1:0]          hold_last_lane;
  logic [OUT_EMPTY_WIDTH-1:0] hold_empty;
  logic [LANE_W-1:0]          lane;

  logic                       hold_full;
  logic                       at_last;
  logic                       in_fire;
  logic                       out_fire;
  logic [IN_EMPTY_WIDTH-1:0]  empty_lanes;
  logic [IN_EMPTY_WIDTH-1:0]  empty_mod;
  logic [LANE_W-1:0]          last_lane_nxt;

  assign hold_full = (state == SHIFT);
  assign at_last   = (lane == hold_last_lane);
  assign in_ready  = !hold_full || (out_ready && at_last);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = hold_full && out_ready;

  // Whole empty lanes at the tail of an eop beat are dropped; the remainder goes to out_empty.
  assign empty_lanes   = in_empty / IN_EMPTY_WIDTH'(OUT_BYTES);
  assign empty_mod     = in_empty % IN_EMPTY_WIDTH'(OUT_BYTES);
  assign last_lane_nxt = in_endofpacket ? (LANE_W'(RATIO - 1) - empty_lanes[LANE_W-1:0])
                                        : LANE_W'(RATIO - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      hold_data      <= '0;
      hold_sop       <= 1'b0;
      hold_eop       <= 1'b0;
      hold_last_lane <= '0;
      hold_empty     <= '0;
      lane           <= '0;
    end else if (in_fire) begin
      // Also covers the final-lane handshake that overlaps a new beat.
      state          <= SHIFT;
      hold_data      <= in_data;
      hold_sop       <= in_startofpacket;
      hold_eop       <= in_endofpacket;
      hold_last_lane <= last_lane_nxt;
      hold_empty     <= OUT_EMPTY_WIDTH'(empty_mod);
      lane           <= '0;
    end else if (out_fire) begin
      if (at_last) begin
        state <= IDLE;
        lane  <= '0;
      end else begin
        lane <= lane + 1'b1;
`ifdef MSGDMA_DWC_LSB_FIRST_EN
        hold_data <= hold_data >> OUT_WIDTH;
`else
        hold_data <= hold_data << OUT_WIDTH;
`endif
      end
    end
  end

  assign out_valid = hold_full;
`ifdef MSGDMA_DWC_LSB_FIRST_EN
  assign out_data  = hold_data[OUT_WIDTH-1:0];
`else
  assign out_data  = hold_data[IN_WIDTH-1 -: OUT_WIDTH];
`endif
  assign out_startofpacket = hold_full && hold_sop && (lane == '0);
  assign out_endofpacket   = hold_full && hold_eop && at_last;
  assign out_empty         = out_endofpacket ? hold_empty : '0;

endmodule

// File: tb/tb_msgdma_st_width_downconverter.sv
// Scoreboard bench for msgdma_st_width_downconverter: directed beats, expected words queued at issue, monitor pops on handshake.
module tb_msgdma_st_width_downconverter;

  typedef struct packed {
    logic [31:0] d;
    logic        sop;
    logic        eop;
    logic [1:0]  emp;
  } word_t;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_data;
  logic         in_startofpacket;
  logic         in_endofpacket;
  logic [4:0]   in_empty;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_startofpacket;
  logic         out_endofpacket;
  logic [1:0]   out_empty;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  word_t exp_q[$];
  int    pop_cyc[$];
  logic  prev_stall = 1'b0;
  word_t stall_snap;

  msgdma_st_width_downconverter dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .in_startofpacket  (in_startofpacket),
    .in_endofpacket    (in_endofpacket),
    .in_empty          (in_empty),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_empty         (out_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: stall stability and in-order scoreboard comparison on every handshake.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (out_valid && prev_stall)
        check("stall_hold", {out_data, out_startofpacket, out_endofpacket, out_empty}, stall_snap);
      if (out_valid && !out_ready) begin
        prev_stall = 1'b1;
        stall_snap = {out_data, out_startofpacket, out_endofpacket, out_empty};
      end else begin
        prev_stall = 1'b0;
      end
      if (out_valid && out_ready) begin
        pop_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word", out_data);
        end else begin
          word_t e;
          e = exp_q.pop_front();
          check("word", {out_data, out_startofpacket, out_endofpacket, out_empty}, e);
        end
      end
    end
  end

  // Expected words of one beat, lane order and trailing-empty trimming from the protocol definition.
  task automatic push_expected(input logic [255:0] d, input logic sop, input logic eop, input logic [4:0] emp);
    int last;
    last = eop ? 7 - (int'(emp) / 4) : 7;
    for (int l = 0; l <= last; l++) begin
      word_t w;
`ifdef MSGDMA_DWC_LSB_FIRST_EN
      w.d = d[l*32 +: 32];
`else
      w.d = d[255 - l*32 -: 32];
`endif
      w.sop = sop && (l == 0);
      w.eop = eop && (l == last);
      w.emp = (eop && (l == last)) ? emp[1:0] : 2'd0;
      exp_q.push_back(w);
    end
  endtask

  // Returns at posedge+1 of the accepting edge with in_valid dropped.
  task automatic send_beat(input logic [255:0] d, input logic sop, input logic eop, input logic [4:0] emp);
    int n;
    push_expected(d, sop, eop, emp);
    in_valid = 1'b1;
    in_data = d;
    in_startofpacket = sop;
    in_endofpacket = eop;
    in_empty = emp;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, exp_q.size(), 0);
  endtask

  function automatic logic [255:0] lanes(input logic [31:0] base);
    logic [255:0] r;
    for (int l = 0; l < 8; l++) r[255 - l*32 -: 32] = base + 32'(7 - l);
    return r;
  endfunction

  initial begin
    int w0;
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_startofpacket = 1'b0;
    in_endofpacket = 1'b0;
    in_empty = '0;
    out_ready = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sideband", {out_startofpacket, out_endofpacket, out_empty}, 0);
    check("rst_out_data", out_data, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("in_ready_after_reset", in_ready, 1);

    // Single-beat packet, words 7..0; in_ready low for lanes 0-6, high on lane 7.
    send_beat(lanes(32'h0), 1'b1, 1'b1, 5'd0);
    for (int i = 0; i < 7; i++) begin
      check("in_ready_busy", in_ready, 0);
      @(posedge clk);
      #1;
    end
    check("in_ready_last_lane", in_ready, 1);
    wait_drain("drain_t1");

    // Two back-to-back non-eop beats: 16 contiguous words.
    w0 = pop_cyc.size();
    send_beat(lanes(32'h1000), 1'b1, 1'b0, 5'd0);
    send_beat(lanes(32'h2000), 1'b0, 1'b0, 5'd0);
    wait_drain("drain_t2");
    check("t2_word_count", pop_cyc.size() - w0, 16);
    check("t2_no_gap", pop_cyc[w0+15] - pop_cyc[w0], 15);

    // eop with empty=13: 5 words, next beat taken on word 4's handshake.
    w0 = pop_cyc.size();
    send_beat(lanes(32'h3000), 1'b0, 1'b1, 5'd13);
    send_beat(lanes(32'h4000), 1'b1, 1'b0, 5'd0);
    wait_drain("drain_t3");
    check("t3_word_count", pop_cyc.size() - w0, 13);
    check("t3_no_gap", pop_cyc[w0+5] - pop_cyc[w0+4], 1);

    // eop with empty=31: one word only.
    w0 = pop_cyc.size();
    send_beat(lanes(32'h5000), 1'b1, 1'b1, 5'd31);
    wait_drain("drain_t4");
    check("t4_word_count", pop_cyc.size() - w0, 1);

    // Stall during word 2: out_ready 1,0,0,1.
    w0 = pop_cyc.size();
    send_beat(lanes(32'h6000), 1'b0, 1'b1, 5'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("stall_valid_held", out_valid, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain("drain_t5");
    check("t5_word_count", pop_cyc.size() - w0, 8);

    // Reset pulse during word 3 discards the rest of the beat.
    send_beat(lanes(32'h7000), 1'b1, 1'b0, 5'd0);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("reset_mid_valid", out_valid, 0);
    check("reset_mid_data", out_data, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("in_ready_after_mid_reset", in_ready, 1);
    w0 = pop_cyc.size();
    send_beat(lanes(32'h8000), 1'b1, 1'b1, 5'd4);
    wait_drain("drain_t6");
    check("t6_word_count", pop_cyc.size() - w0, 7);

    repeat (3) @(posedge clk);
    #1;
    check("idle_out_valid", out_valid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
